ex_mem_buffer: RTL and testbench
================================

EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

Interface
REQ-001 SHALL have parameter OVF_CNT_W, default 8, width of the saturating overflow event counter.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have flush  input  1  synchronous discard of all buffered entries.
REQ-005 SHALL have in_valid  input  1 / in_ready  output  1  upstream (execute-side) handshake.
REQ-006 SHALL have alu_result  input  32 / alu_zero, alu_overflow, alu_cout  input  1 each  execute ALU outputs.
REQ-007 SHALL have rd  input  5 / reg_write, mem_read, mem_write, branch  input  1 each / store_data  input  32  control/data travelling with the result.
REQ-008 SHALL have out_valid  output  1 / out_ready  input  1  downstream (memory-side) handshake.
REQ-009 SHALL have out_result  output  32 / out_zero, out_overflow, out_cout, out_reg_write, out_mem_read, out_mem_write  output  1 each / out_rd  output  5 / out_store_data  output  32  registered copies of the head entry.
REQ-010 SHALL have out_branch_taken  output  1  head entry branch AND zero.
REQ-011 SHALL have ovf_count  output  OVF_CNT_W  count of accepted entries with alu_overflow=1.

Function
REQ-012 SHALL be a 2-entry buffer: main register (drives outputs) plus skid register; fall-through latency 1 cycle.
REQ-013 SHALL accept an entry on a clock edge iff in_valid=1 and in_ready=1; deliver iff out_valid=1 and out_ready=1.
REQ-014 SHALL drive in_ready = NOT skid_valid, from registered state only (no combinational path from out_ready).
REQ-015 SHALL drive out_valid = main_valid; all out_* fields SHALL come directly from main-register flops.
REQ-016 States (main_valid, skid_valid): EMPTY(0,0), ONE(1,0), FULL(1,1); (0,1) SHALL be unreachable.
REQ-017 EMPTY: accept -> ONE, entry into main.
REQ-018 ONE: accept and deliver -> ONE, new entry into main; accept only -> FULL, entry into skid; deliver only -> EMPTY; neither -> hold.
REQ-019 FULL: in_ready=0; deliver -> ONE, skid moves to main; otherwise hold.
REQ-020 Order SHALL be strictly FIFO; no entry dropped or duplicated absent flush/reset.
REQ-021 Held entries SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 out_branch_taken SHALL equal out_branch AND out_zero when out_valid=1, else 0.
REQ-023 ovf_count SHALL increment by 1 on each accepted entry with alu_overflow=1, saturate at 2^OVF_CNT_W-1, and not change on flush.
REQ-024 flush=1 SHALL clear main_valid and skid_valid next edge, override any same-cycle accept (accepted-and-flushed entry discarded, not counted).
REQ-025 Data fields of invalid entries are don't-care; valid bits SHALL never be X after reset.

Reset
REQ-026 reset=1 at an edge SHALL force EMPTY, ovf_count=0, all out_* data fields=0; reset SHALL override flush and accept.
REQ-027 During reset cycle outputs SHALL show out_valid=0, in_ready=1 from the next edge; reset mid-transfer SHALL discard both entries.

Verification
REQ-028 Stream: out_ready=1, 3 back-to-back entries result 0x5,0x6,0x7 -> out_result 0x5,0x6,0x7 on consecutive cycles, in_ready constant 1.
REQ-029 Backpressure: out_ready=0, send 0xA,0xB,0xC -> 0xA,0xB accepted, in_ready=0 after second, 0xC held; raise out_ready -> 0xA,0xB,0xC delivered in order, nothing lost.
REQ-030 Branch: entry branch=1 alu_zero=1 -> out_branch_taken=1; branch=1 alu_zero=0 -> 0; out_valid=0 -> 0.
REQ-031 Overflow: OVF_CNT_W=2, 5 accepted entries with alu_overflow=1 -> ovf_count 1,2,3,3,3; flushed entry with overflow=1 -> no increment.
REQ-032 Flush in FULL with in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, incoming entry absent downstream.
REQ-033 Reset while FULL with ovf_count=3 -> next cycle out_valid=0, in_ready=1, ovf_count=0, out_result=0x00000000.

Source files
------------

// File: rtl/ex_mem_buffer.sv
// ex_mem_buffer: EX/MEM pipeline buffer built as a 2-entry skid buffer.
// The main register drives every output. The skid register catches one extra
// entry, so in_ready depends only on registered state and never on out_ready.
//
// Ports:
//   clk, reset (synchronous, active-high), flush (synchronous discard)
//   in_valid / in_ready    : execute-side handshake
//   alu_*, rd, reg_write, mem_read, mem_write, branch, store_data : entry fields
//   out_valid / out_ready  : memory-side handshake
//   out_*                  : head entry, taken straight from main-register flops
//   out_branch_taken       : head branch AND zero, qualified by out_valid
//   ovf_count              : saturating count of accepted overflow entries
module ex_mem_buffer #(
    parameter int unsigned OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    input  logic                 alu_cout,
    input  logic [4:0]           rd,
    input  logic                 reg_write,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 branch,
    input  logic [31:0]          store_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic                 out_zero,
    output logic                 out_overflow,
    output logic                 out_cout,
    output logic                 out_reg_write,
    output logic                 out_mem_read,
    output logic                 out_mem_write,
    output logic [4:0]           out_rd,
    output logic [31:0]          out_store_data,
    output logic                 out_branch_taken,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    // State encoding is {main_valid, skid_valid}; (0,1) has no code point.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        overflow;
        logic        cout;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic [31:0] store_data;
    } entry_t;

    state_t                 state_q, state_d;
    entry_t                 main_q, main_d;
    entry_t                 skid_q, skid_d;
    logic [OVF_CNT_W-1:0]   ovf_q, ovf_d;

    entry_t in_entry;
    logic   accept;
    logic   deliver;

    assign in_entry = '{
        result:     alu_result,
        zero:       alu_zero,
        overflow:   alu_overflow,
        cout:       alu_cout,
        rd:         rd,
        reg_write:  reg_write,
        mem_read:   mem_read,
        mem_write:  mem_write,
        branch:     branch,
        store_data: store_data
    };

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = in_entry;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    main_d = in_entry;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_entry;
                end else if (deliver) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (deliver) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (accept && alu_overflow && (ovf_q != '1)) begin
            ovf_d = ovf_q + OVF_CNT_W'(1);
        end

        // Flush discards everything, including an entry accepted this cycle,
        // so that entry must not be counted either.
        if (flush) begin
            state_d = EMPTY;
            ovf_d   = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_result       = main_q.result;
    assign out_zero         = main_q.zero;
    assign out_overflow     = main_q.overflow;
    assign out_cout         = main_q.cout;
    assign out_reg_write    = main_q.reg_write;
    assign out_mem_read     = main_q.mem_read;
    assign out_mem_write    = main_q.mem_write;
    assign out_rd           = main_q.rd;
    assign out_store_data   = main_q.store_data;
    assign out_branch_taken = out_valid && main_q.branch && main_q.zero;
    assign ovf_count        = ovf_q;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb_ex_mem_buffer: directed self-checking bench for ex_mem_buffer with a
// 2-bit overflow counter so that saturation is reachable.
module tb_ex_mem_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;
    logic        alu_cout;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [31:0] store_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic        out_cout;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [4:0]  out_rd;
    logic [31:0] out_store_data;
    logic        out_branch_taken;
    logic [1:0]  ovf_count;

    int tests = 0;
    int fails = 0;

    ex_mem_buffer #(.OVF_CNT_W(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .alu_result       (alu_result),
        .alu_zero         (alu_zero),
        .alu_overflow     (alu_overflow),
        .alu_cout         (alu_cout),
        .rd               (rd),
        .reg_write        (reg_write),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .branch           (branch),
        .store_data       (store_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_zero         (out_zero),
        .out_overflow     (out_overflow),
        .out_cout         (out_cout),
        .out_reg_write    (out_reg_write),
        .out_mem_read     (out_mem_read),
        .out_mem_write    (out_mem_write),
        .out_rd           (out_rd),
        .out_store_data   (out_store_data),
        .out_branch_taken (out_branch_taken),
        .ovf_count        (ovf_count)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] res);
        in_valid   = 1'b1;
        alu_result = res;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_result = '0; alu_zero = 1'b0; alu_overflow = 1'b0; alu_cout = 1'b0;
        rd = '0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        branch = 1'b0; store_data = '0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ovf", 32'(ovf_count), 32'd0);
        check("rst_result", out_result, 32'h0);
        check("rst_br_taken", 32'(out_branch_taken), 32'd0);

        // Streaming with out_ready held high
        out_ready = 1'b1;
        send(32'h5); tick();
        check("stream_r5", out_result, 32'h5);
        check("stream_v5", 32'(out_valid), 32'd1);
        check("stream_rdy5", 32'(in_ready), 32'd1);
        send(32'h6); tick();
        check("stream_r6", out_result, 32'h6);
        check("stream_rdy6", 32'(in_ready), 32'd1);
        send(32'h7); tick();
        check("stream_r7", out_result, 32'h7);
        check("stream_rdy7", 32'(in_ready), 32'd1);
        in_valid = 1'b0; tick();
        check("stream_drain", 32'(out_valid), 32'd0);

        // Backpressure: fill both registers, hold, then drain in order
        out_ready = 1'b0;
        rd = 5'd9;
        send(32'hA); tick();
        check("bp_rA", out_result, 32'hA);
        check("bp_rdy_one", 32'(in_ready), 32'd1);
        rd = 5'd3;
        send(32'hB); tick();
        check("bp_hold_rA", out_result, 32'hA);
        check("bp_rdy_full", 32'(in_ready), 32'd0);
        send(32'hC); tick();
        check("bp_stable_rA", out_result, 32'hA);
        check("bp_stable_rd", 32'(out_rd), 32'd9);
        check("bp_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1; tick();
        check("bp_rB", out_result, 32'hB);
        check("bp_rB_rd", 32'(out_rd), 32'd3);
        check("bp_rdy_again", 32'(in_ready), 32'd1);
        tick();
        check("bp_rC", out_result, 32'hC);
        check("bp_vC", 32'(out_valid), 32'd1);
        in_valid = 1'b0; tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Branch resolution and field transport
        out_ready = 1'b0;
        branch = 1'b1; alu_zero = 1'b1; alu_cout = 1'b1; rd = 5'd17;
        reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
        store_data = 32'hDEADBEEF;
        send(32'h100); tick();
        check("br_taken", 32'(out_branch_taken), 32'd1);
        check("br_zero", 32'(out_zero), 32'd1);
        check("br_cout", 32'(out_cout), 32'd1);
        check("br_rd", 32'(out_rd), 32'd17);
        check("br_regw", 32'(out_reg_write), 32'd1);
        check("br_memr", 32'(out_mem_read), 32'd0);
        check("br_memw", 32'(out_mem_write), 32'd1);
        check("br_store", out_store_data, 32'hDEADBEEF);
        check("br_ovf_bit", 32'(out_overflow), 32'd0);
        out_ready = 1'b1;
        alu_zero = 1'b0; alu_cout = 1'b0; reg_write = 1'b0; mem_write = 1'b0;
        mem_read = 1'b1; store_data = 32'h0;
        send(32'h104); tick();
        check("br_not_taken", 32'(out_branch_taken), 32'd0);
        check("br_memr2", 32'(out_mem_read), 32'd1);
        alu_zero = 1'b1; in_valid = 1'b0; tick();
        check("br_invalid", 32'(out_branch_taken), 32'd0);
        branch = 1'b0; alu_zero = 1'b0; mem_read = 1'b0;

        // Overflow counter: flushed entry is not counted, then saturation
        alu_overflow = 1'b1; flush = 1'b1;
        send(32'h20); tick();
        flush = 1'b0;
        check("ovf_flushed", 32'(ovf_count), 32'd0);
        check("ovf_flushed_v", 32'(out_valid), 32'd0);
        send(32'h21); tick();
        check("ovf_1", 32'(ovf_count), 32'd1);
        check("ovf_out_bit", 32'(out_overflow), 32'd1);
        tick();
        check("ovf_2", 32'(ovf_count), 32'd2);
        tick();
        check("ovf_3", 32'(ovf_count), 32'd3);
        tick();
        check("ovf_sat4", 32'(ovf_count), 32'd3);
        tick();
        check("ovf_sat5", 32'(ovf_count), 32'd3);
        in_valid = 1'b0; alu_overflow = 1'b0; tick();
        check("ovf_drain", 32'(out_valid), 32'd0);

        // Flush in ONE with a same-cycle accept
        out_ready = 1'b0;
        send(32'h30); tick();
        flush = 1'b1;
        send(32'h31); tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_one_v", 32'(out_valid), 32'd0);
        check("fl_one_rdy", 32'(in_ready), 32'd1);

        // Flush in FULL with in_valid high
        send(32'h11); tick();
        send(32'h12); tick();
        check("fl_full_pre", 32'(in_ready), 32'd0);
        flush = 1'b1;
        send(32'h13); tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_full_v", 32'(out_valid), 32'd0);
        check("fl_full_rdy", 32'(in_ready), 32'd1);
        check("fl_ovf_kept", 32'(ovf_count), 32'd3);
        out_ready = 1'b1; tick();
        check("fl_absent", 32'(out_valid), 32'd0);

        // Reset while FULL with a saturated counter
        out_ready = 1'b0;
        send(32'h41); tick();
        send(32'h42); tick();
        check("rf_pre_full", 32'(in_ready), 32'd0);
        check("rf_pre_ovf", 32'(ovf_count), 32'd3);
        reset = 1'b1; flush = 1'b1;
        send(32'h43); tick();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check("rf_v", 32'(out_valid), 32'd0);
        check("rf_rdy", 32'(in_ready), 32'd1);
        check("rf_ovf", 32'(ovf_count), 32'd0);
        check("rf_result", out_result, 32'h0);
        out_ready = 1'b1; tick();
        check("rf_discarded", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
